// File: rtl/sll_seq.sv
// sll_seq: multi-cycle 16-bit logical left shifter for the ALU.
// One log-shifter stage is applied per clock over four SHIFT cycles, so the
// latency is fixed regardless of the shift amount. The block also produces
// carry-out and zero flags and holds its results until the next operation.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only while idle
//   a      - 16-bit operand, captured on acceptance
//   b      - 4-bit shift amount (0..15), captured on acceptance
//   busy   - high from the cycle after acceptance through the done cycle
//   done   - one-cycle pulse marking out/carry/zero valid
//   out    - a << b, zero-filled from the LSB end
//   carry  - last bit shifted out (a[16-b]), 0 when b == 0
//   zero   - out == 0
module sll_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [3:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] out,
    output logic        carry,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  k;
    logic [15:0] work;
    logic [15:0] work_shifted;
    logic [3:0]  amt;
    logic        carry_next;
    logic [3:0]  carry_idx;
    logic        carry_calc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (k == 2'd3) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One log-shifter stage: stage k shifts by 2^k when amt[k] is set.
    always_comb begin
        work_shifted = work;
        if (amt[k]) begin
            unique case (k)
                2'd0: work_shifted = {work[14:0], 1'b0};
                2'd1: work_shifted = {work[13:0], 2'b00};
                2'd2: work_shifted = {work[11:0], 4'h0};
                2'd3: work_shifted = {work[7:0],  8'h00};
                default: work_shifted = work;
            endcase
        end
    end

    // 16-b computed modulo 16: for b = 1..15 this is exactly the index of
    // the last bit shifted out; b = 0 is masked separately.
    always_comb begin
        carry_idx  = 4'd0 - b;
        carry_calc = (b != 4'd0) ? a[carry_idx] : 1'b0;
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work       <= '0;
            amt        <= '0;
            k          <= '0;
            carry_next <= 1'b0;
            out        <= '0;
            carry      <= 1'b0;
            zero       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        work       <= a;
                        amt        <= b;
                        carry_next <= carry_calc;
                        k          <= '0;
                    end
                end
                SHIFT: begin
                    work <= work_shifted;
                    k    <= k + 2'd1;
                    if (k == 2'd3) begin
                        out   <= work_shifted;
                        carry <= carry_next;
                        zero  <= (work_shifted == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/sll_seq.md
# sll_seq

Multi-cycle 16-bit logical left shifter for the processor ALU; it complements the combinational right shifter. It takes one operand and a 4-bit shift amount through a start/done handshake and applies one log-shifter stage per clock, giving fixed-latency results. It also produces carry-out and zero flags for the flag register, and holds its result until the next accepted operation.

## Interface
- No parameters. Width is fixed at 16-bit data and a 4-bit shift amount.
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only while busy=0
- a  input  16  operand; captured when start is accepted
- b  input  4  shift amount 0..15; captured when start is accepted
- busy  output  1  high from the cycle after acceptance through the done cycle
- done  output  1  one-cycle pulse marking out/carry/zero as valid
- out  output  16  a << b, zero-filled from the LSB end
- carry  output  1  last bit shifted out: a[16-b] for b=1..15, 0 for b=0
- zero  output  1  1 when out == 16'h0000

## Operation
- States: IDLE, SHIFT, DONE. A 2-bit stage counter k runs 0..3 in SHIFT.
- IDLE, start=1:
  - latch a into the working register and b into the amount register;
  - compute and latch carry_next from the latched a and b;
  - go to SHIFT with k=0.
- IDLE, start=0: hold state. All outputs hold their last values.
- SHIFT, each cycle:
  - working register <= b[k] ? (work << 2^k) : work, with zeros filled in at the low end;
  - k increments;
  - at k=3 go to DONE.
- On the final SHIFT edge (k=3):
  - out <= shifted value;
  - carry <= carry_next;
  - zero <= (shifted value == 0).
- DONE: done=1 for exactly one cycle, then go to IDLE.
- b=0: all four stages still execute with no change. out=a and carry=0. Latency is unchanged, with no fast path.
- start while busy=1, including during the DONE cycle, is ignored. It is neither queued nor latched.
- out, carry and zero change only on the final SHIFT edge or on reset. Between operations they hold their values.
- Changes on a or b after acceptance have no effect on the operation in flight.
- Arithmetic: only the low 16 bits are kept. Bits shifted beyond bit 15 are discarded; carry alone records bit a[16-b].

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, k=0;
  - out=16'h0000, carry=0, zero=0, busy=0, done=0;
  - the working and amount registers are cleared.
- Reset asserted mid-operation aborts the operation immediately. No done pulse follows. After rst_n deasserts, the block is in IDLE.
- Let start be accepted on edge E0:
  - busy=1 after E0;
  - SHIFT stages 0..3 execute on edges E1..E4;
  - out, carry and zero are valid after E4;
  - done=1 in the cycle between E4 and E5;
  - busy=0 and done=0 after E5.
- Latency is 5 cycles from the accepting edge to the done deassertion edge. A new start is first accepted on E5, so throughput is one operation per 5 cycles.
- done and busy are registered outputs, with no combinational path from start.

## Test plan
- a=16'h0001, b=15, start pulse -> busy high for 5 cycles; done pulses after the 4th shift edge; out=16'h8000, carry=0, zero=0.
- a=16'hF00F, b=4 -> out=16'h00F0, carry=1 (a[12]), zero=0.
- a=16'h8000, b=1 -> out=16'h0000, carry=1, zero=1; out stays at 16'h0000 for 10 idle cycles afterwards.
- a=16'hA5A5, b=0 -> out=16'hA5A5, carry=0, with done still on the same 5-cycle schedule.
- Accept a=16'h0003, b=2, then pulse start with a=16'hFFFF, b=8 during SHIFT and again during DONE -> single result out=16'h000C, exactly one done pulse, no second operation.
- Start a=16'h1234, b=3, then assert rst_n low after 2 SHIFT cycles -> out=0, carry=0, zero=0, busy=0 immediately, with no done pulse; a new operation a=16'h1234, b=3 then gives out=16'h91A0, carry=0.
